// File: rtl/cpu_controller_pkg.sv
// cpu_controller_pkg: shared types and constants for the instruction-sequencing
// controller: FSM state encoding, instruction field layout, opcode/op codes
// and write-data (vsel) select codes.
package cpu_controller_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned REG_W   = 3;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_e;

  // Instruction word layout, MSB first.
  typedef struct packed {
    logic [2:0]       opcode;
    logic [1:0]       op;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rd;
    logic [1:0]       sh;
    logic [REG_W-1:0] rm;
  } instr_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'd0;
  localparam logic [1:0] VSEL_PC    = 2'd1;
  localparam logic [1:0] VSEL_IMM8  = 2'd2;
  localparam logic [1:0] VSEL_MDATA = 2'd3;

endpackage

// File: rtl/instr_dec.sv
// instr_dec: splits the instruction register into its fields and produces
// the sign-extended 8-bit and 5-bit immediates.
//   ir_i      : instruction register contents
//   fields_o  : opcode/op/Rn/Rd/sh/Rm
//   sximm8_o  : sign-extended IR[7:0]
//   sximm5_o  : sign-extended IR[4:0]
module instr_dec
  import cpu_controller_pkg::*;
(
  input  logic [INSTR_W-1:0] ir_i,
  output instr_t             fields_o,
  output logic [INSTR_W-1:0] sximm8_o,
  output logic [INSTR_W-1:0] sximm5_o
);

  assign fields_o = instr_t'(ir_i);
  assign sximm8_o = {{(INSTR_W-8){ir_i[7]}}, ir_i[7:0]};
  assign sximm5_o = {{(INSTR_W-5){ir_i[4]}}, ir_i[4:0]};

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: holds the instruction register and sequences the datapath
// through WAIT/DECODE/WRITE_IMM/GET_A/GET_B/ALU/WRITE_REG.
//   clk, reset        : clock, synchronous active-high reset
//   s, load, in       : start pulse, IR load enable, instruction word
//   w                 : idle flag (1 only in WAIT)
//   readnum, writenum : register-file selects
//   vsel              : write-data select
//   loada/b/c, loads  : datapath register strobes
//   asel, bsel, write : operand selects and register-file write enable
//   shift, ALUop      : shifter and ALU controls
//   sximm8, sximm5    : sign-extended immediates from the IR
// Outputs are a Moore decode of the state register and IR.
module cpu_controller
  import cpu_controller_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               s,
  input  logic               load,
  input  logic [INSTR_W-1:0] in,
  output logic               w,
  output logic [REG_W-1:0]   readnum,
  output logic [REG_W-1:0]   writenum,
  output logic [1:0]         vsel,
  output logic               loada,
  output logic               loadb,
  output logic               loadc,
  output logic               loads,
  output logic               asel,
  output logic               bsel,
  output logic               write,
  output logic [1:0]         shift,
  output logic [1:0]         ALUop,
  output logic [INSTR_W-1:0] sximm8,
  output logic [INSTR_W-1:0] sximm5
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q;
  instr_t             f;
  logic               is_mov_imm, is_mov_reg, is_mvn, is_cmp, is_alu3;

  instr_dec u_instr_dec (
    .ir_i     (ir_q),
    .fields_o (f),
    .sximm8_o (sximm8),
    .sximm5_o (sximm5)
  );

  assign is_mov_imm = (f.opcode == OPC_MOV) && (f.op == OP_MOV_IMM);
  assign is_mov_reg = (f.opcode == OPC_MOV) && (f.op == OP_MOV_REG);
  assign is_mvn     = (f.opcode == OPC_ALU) && (f.op == OP_MVN);
  assign is_cmp     = (f.opcode == OPC_ALU) && (f.op == OP_CMP);
  assign is_alu3    = (f.opcode == OPC_ALU) &&
                      ((f.op == OP_ADD) || (f.op == OP_CMP) || (f.op == OP_AND));

  // State and IR; IR only accepts a new word while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load && (state_q == S_WAIT)) ir_q <= in;
    end
  end

  // Next state and Moore outputs.
  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    vsel     = VSEL_C;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    write    = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;

    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Unrecognised encodings fall back to WAIT without touching the datapath.
        if (is_mov_imm)                state_d = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn) state_d = S_GET_B;
        else if (is_alu3)              state_d = S_GET_A;
        else                           state_d = S_WAIT;
      end
      S_WRITE_IMM: begin
        vsel     = VSEL_IMM8;
        writenum = f.rn;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_GET_A: begin
        readnum = f.rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = f.rm;
        loadb   = 1'b1;
        state_d = S_ALU;
      end
      S_ALU: begin
        shift = f.sh;
        ALUop = is_mov_reg ? 2'b00 : f.op;
        // Single-operand ops ignore A by selecting the zero operand.
        asel  = is_mov_reg || is_mvn;
        if (is_cmp) begin
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        vsel     = VSEL_C;
        writenum = f.rd;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase

    // Reset must block datapath side effects even mid-instruction.
    if (reset) begin
      write = 1'b0;
      loada = 1'b0;
      loadb = 1'b0;
      loadc = 1'b0;
      loads = 1'b0;
    end
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: s  in  1  start pulse, sampled only in WAIT.
REQ-004 SHALL have ports: load  in  1  instruction-register load enable.
REQ-005 SHALL have ports: in  in  16  instruction word.
REQ-006 SHALL have ports: w  out  1  idle flag, 1 only in WAIT.
REQ-007 SHALL have ports: readnum, writenum  out  3 each  register selects.
REQ-008 SHALL have ports: vsel  out  2  write-data select: 0=C, 1=PC, 2=sximm8, 3=mdata.
REQ-009 SHALL have ports: loada, loadb, loadc, loads, asel, bsel, write  out  1 each  datapath strobes and selects.
REQ-010 SHALL have ports: shift, ALUop  out  2 each  shifter and ALU controls.
REQ-011 SHALL have ports: sximm8, sximm5  out  16 each  sign-extended IR[7:0] and IR[4:0].

Function
REQ-012 SHALL hold a 16-bit instruction register (IR) that captures in on a clk edge when load=1 and w=1; load SHALL be ignored while w=0.
REQ-013 SHALL decode fields from IR: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0].
REQ-014 SHALL implement states WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG, with outputs a function of state and IR only (Moore).
REQ-015 WAIT: s=1 -> DECODE, else stay in WAIT; s and load in the same cycle SHALL execute the newly loaded word.
REQ-016 DECODE: 110/10 (MOV imm) -> WRITE_IMM; 110/00 (MOV reg) or 101/11 (MVN) -> GET_B; 101/00 (ADD), 101/01 (CMP), 101/10 (AND) -> GET_A; any other encoding -> WAIT with no strobes.
REQ-017 WRITE_IMM: vsel=2, writenum=Rn, write=1 -> WAIT.
REQ-018 GET_A: readnum=Rn, loada=1 -> GET_B.
REQ-019 GET_B: readnum=Rm, loadb=1 -> ALU.
REQ-020 ALU: shift=sh, bsel=0, ALUop=op (MOV reg forces ALUop=00), asel=1 for MOV reg and MVN, else 0.
REQ-021 ALU: loadc=1 and next state WRITE_REG for all ops except CMP; CMP SHALL assert loads=1 and loadc=0 and return to WAIT.
REQ-022 WRITE_REG: vsel=0, writenum=Rd, write=1 -> WAIT.
REQ-023 SHALL drive all strobes not listed for the current state to 0 and all selects/readnum/writenum to 0.
REQ-024 Cycles with w=0 after s is accepted: MOV imm 2, MOV reg/MVN/CMP 4, ADD/AND 5.

Reset
REQ-025 reset=1 at a clk edge SHALL set state to WAIT and IR to 0x0000, overriding s and load.
REQ-026 While reset=1, write, loada, loadb, loadc and loads SHALL be forced to 0 combinationally, including when reset arrives mid-instruction.
REQ-027 After reset, w=1 and all outputs SHALL be 0 except w.

Structure
REQ-028 A shared package SHALL hold the state encoding, opcode/op constants and vsel codes (VSEL_C=0, VSEL_PC=1, VSEL_IMM8=2, VSEL_MDATA=3).
REQ-029 Field extraction and sign extension SHALL sit in one sub-module, instr_dec; the IR and the FSM stay in cpu_controller.

Verification
REQ-030 Scenario: load in=0xD105 (MOV R1,#5), then s -> exactly 2 cycles with w=0; in WRITE_IMM: write=1, writenum=1, vsel=2, sximm8=0x0005.
REQ-031 Scenario: in=0xD2FF (MOV R2,#-1) -> sximm8=0xFFFF; in=0xA0BF -> sximm5=0xFFFF.
REQ-032 Scenario: ADD R3,R1,R2 (0xA162) -> states DECODE, GET_A(readnum=1), GET_B(readnum=2), ALU(asel=0, loadc=1), WRITE_REG(writenum=3, vsel=0) -> WAIT; w=0 for 5 cycles.
REQ-033 Scenario: CMP R1,R2 (0xA902) -> loads=1 and loadc=0 in ALU, write never asserted, w=0 for 4 cycles.
REQ-034 Scenario: apply load=1 with in=0xFFFF during GET_A -> IR unchanged; assert reset during ALU -> write stays 0, next cycle state=WAIT, IR=0, w=1.
REQ-035 Scenario: illegal word 0xE000, then s -> DECODE then WAIT, with no strobe asserted.
